// File: rtl/eth_stream_pkg.sv
// eth_stream_pkg
// Shared constants, types and helpers for the 16-bit FIFO to byte-stream
// unpacker.
//   Q_DEPTH    : number of words the unpacker may hold, counting a read
//                still in flight.
//   byte_sel_e : which byte of the head word is on the output.
//   cnt_width  : width needed for a 0..frame_bytes-1 byte counter.
package eth_stream_pkg;

  localparam logic [1:0] Q_DEPTH = 2'd2;

  typedef enum logic {
    SEL_FIRST  = 1'b0,
    SEL_SECOND = 1'b1
  } byte_sel_e;

  // Width of a counter running 0..frame_bytes-1. A 2-byte frame still
  // needs one bit.
  function automatic int cnt_width(input int frame_bytes);
    return (frame_bytes > 2) ? $clog2(frame_bytes) : 1;
  endfunction

endpackage

// File: rtl/word_skid_q2.sv
// word_skid_q2
// Two-entry in-order word queue. A push and a pop may happen in the same
// cycle; the count then stays the same and order is preserved.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data at the tail
//   push_data   : word to store
//   pop         : drop the head entry (ignored when empty)
//   count       : number of stored words, 0..2
//   head        : oldest stored word (0 after reset)
module word_skid_q2
  import eth_stream_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         pop_ok;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    pop_ok  = pop && (count_q != 2'd0);

    case ({push, pop_ok})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d  = push_data;
          count_d = 2'd1;
        end else if (count_q < Q_DEPTH) begin
          tail_d  = push_data;
          count_d = count_q + 2'd1;
        end
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Head leaves while a new word arrives: with one entry the new
        // word becomes the head, with two it moves in behind the old tail.
        if (count_q == 2'd1) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = head_q;

endmodule

// File: rtl/fifo16_byte_unpack.sv
// fifo16_byte_unpack
// Reads 16-bit words from a standard-mode FIFO (data one cycle after the
// read strobe) and emits them as a valid/ready byte stream, framed into
// FRAME_BYTES-byte frames with m_last on each frame's final byte.
// Ports:
//   clk, rst_n  : clock (FIFO read clock), asynchronous active-low reset
//   fifo_dout   : FIFO read data
//   fifo_empty  : FIFO empty flag
//   fifo_rd_en  : FIFO read strobe
//   m_data      : output byte
//   m_valid     : output byte valid
//   m_ready     : downstream accept
//   m_last      : final byte of a frame
//
// Byte-select state:
//   state      | meaning
//   SEL_FIRST  | head word's first byte (per MSB_FIRST) is on m_data
//   SEL_SECOND | head word's second byte is on m_data; accept pops head
module fifo16_byte_unpack
  import eth_stream_pkg::*;
#(
  parameter int FRAME_BYTES = 64,
  parameter int MSB_FIRST   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] fifo_dout,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last
);

  localparam int                CNT_W    = cnt_width(FRAME_BYTES);
  localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(FRAME_BYTES - 1);

  byte_sel_e        sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             inflight_q, inflight_d;
  logic             run_q, run_d;

  logic [1:0]       q_count;
  logic [15:0]      q_head;
  logic             q_pop;
  logic             xfer;
  logic [7:0]       first_byte;
  logic [7:0]       second_byte;

  word_skid_q2 #(.W(16)) u_q (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (fifo_dout),
    .pop       (q_pop),
    .count     (q_count),
    .head      (q_head)
  );

  always_comb begin
    // run_q keeps the read strobe low during reset and the first cycle
    // after it, while still depending only on registered state.
    fifo_rd_en  = run_q && !fifo_empty &&
                  ((q_count + {1'b0, inflight_q}) < Q_DEPTH);

    first_byte  = (MSB_FIRST != 0) ? q_head[15:8] : q_head[7:0];
    second_byte = (MSB_FIRST != 0) ? q_head[7:0]  : q_head[15:8];

    m_valid     = (q_count != 2'd0);
    m_data      = 8'h00;
    if (m_valid) begin
      m_data = (sel_q == SEL_SECOND) ? second_byte : first_byte;
    end
    m_last      = m_valid && (cnt_q == LAST_IDX);

    xfer        = m_valid && m_ready;
    q_pop       = xfer && (sel_q == SEL_SECOND);

    run_d       = 1'b1;
    inflight_d  = fifo_rd_en;

    sel_d       = sel_q;
    cnt_d       = cnt_q;
    if (xfer) begin
      sel_d = (sel_q == SEL_FIRST) ? SEL_SECOND : SEL_FIRST;
      cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q      <= SEL_FIRST;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      run_q      <= 1'b0;
    end else begin
      sel_q      <= sel_d;
      cnt_q      <= cnt_d;
      inflight_q <= inflight_d;
      run_q      <= run_d;
    end
  end

endmodule
